ccff_loader: RTL

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams bitstream words LSB-first into a serial
// flip-flop chain, or reads the chain back non-destructively by recirculating it.
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              readback,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BL_W  = $clog2(WORD_W + 1);
    localparam int SUM_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RB   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  shift_cnt_r;
    logic [WORD_W-1:0] sreg_r;
    logic [BL_W-1:0]   bits_left_r;
    logic [WORD_W-1:0] coll_r;
    logic [WORD_W-1:0] coll_mask_r;
    logic [WORD_W-1:0] rb_data_r;
    logic              rb_valid_r;
    logic              busy_r;
    logic              done_r;

    logic              shift_en_s;
    logic              head_s;
    logic              s_ready_s;
    logic              accept_s;
    logic              last_shift_s;
    logic              cnt_full_s;
    logic              word_full_s;
    logic              rb_accept_s;
    logic [SUM_W-1:0]  sched_s;
    logic [SUM_W-1:0]  remain_s;
    logic [BL_W-1:0]   load_bits_s;
    logic [WORD_W-1:0] coll_next_s;

    // Shift enable, head data, handshake and word-length decode for the current cycle.
    always_comb begin
        shift_en_s  = 1'b0;
        head_s      = 1'b0;
        s_ready_s   = 1'b0;
        sched_s     = SUM_W'(shift_cnt_r) + SUM_W'(bits_left_r);
        remain_s    = SUM_W'(CHAIN_LEN) - sched_s;
        cnt_full_s  = (shift_cnt_r == CNT_W'(CHAIN_LEN));
        rb_accept_s = rb_valid_r & rb_ready;
        // The final word may be only partly needed; load just the bits the chain still lacks.
        if (remain_s >= SUM_W'(WORD_W)) begin
            load_bits_s = BL_W'(WORD_W);
        end else begin
            load_bits_s = remain_s[BL_W-1:0];
        end
        case (state_r)
            ST_LOAD: begin
                shift_en_s = (bits_left_r != BL_W'(0));
                head_s     = shift_en_s & sreg_r[0];
                s_ready_s  = ((bits_left_r == BL_W'(0)) ||
                              ((bits_left_r == BL_W'(1)) && shift_en_s)) &&
                             (sched_s < SUM_W'(CHAIN_LEN));
            end
            ST_RB: begin
                shift_en_s = !cnt_full_s && (!rb_valid_r || rb_ready);
                head_s     = ccff_tail;
            end
            default: begin
                shift_en_s = 1'b0;
                head_s     = 1'b0;
                s_ready_s  = 1'b0;
            end
        endcase
        accept_s     = s_ready_s & s_valid;
        last_shift_s = shift_en_s && (shift_cnt_r == CNT_W'(CHAIN_LEN - 1));
        coll_next_s  = ccff_tail ? (coll_r | coll_mask_r) : coll_r;
        word_full_s  = coll_mask_r[WORD_W-1] || last_shift_s;
    end

    // Operation sequencing.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = readback ? ST_RB : ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_shift_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RB: begin
                // Leave only once every shift is done and the last word has been taken.
                if (cnt_full_s && rb_accept_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_RB;
                end
            end
            ST_FIN:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, counters, load shift register and readback collector.
    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            shift_cnt_r <= CNT_W'(0);
            sreg_r      <= WORD_W'(0);
            bits_left_r <= BL_W'(0);
            coll_r      <= WORD_W'(0);
            coll_mask_r <= WORD_W'(1);
            rb_data_r   <= WORD_W'(0);
            rb_valid_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_FIN);
            case (state_r)
                ST_IDLE: begin
                    shift_cnt_r <= CNT_W'(0);
                    sreg_r      <= WORD_W'(0);
                    bits_left_r <= BL_W'(0);
                    coll_r      <= WORD_W'(0);
                    coll_mask_r <= WORD_W'(1);
                    rb_valid_r  <= 1'b0;
                end
                ST_LOAD: begin
                    if (shift_en_s) begin
                        shift_cnt_r <= shift_cnt_r + CNT_W'(1);
                    end
                    if (accept_s) begin
                        sreg_r      <= s_data;
                        bits_left_r <= load_bits_s;
                    end else if (shift_en_s) begin
                        sreg_r      <= sreg_r >> 1;
                        bits_left_r <= bits_left_r - BL_W'(1);
                    end
                end
                ST_RB: begin
                    if (shift_en_s) begin
                        shift_cnt_r <= shift_cnt_r + CNT_W'(1);
                        if (word_full_s) begin
                            rb_data_r   <= coll_next_s;
                            coll_r      <= WORD_W'(0);
                            coll_mask_r <= WORD_W'(1);
                        end else begin
                            coll_r      <= coll_next_s;
                            coll_mask_r <= coll_mask_r << 1;
                        end
                    end
                    if (shift_en_s && word_full_s) begin
                        rb_valid_r <= 1'b1;
                    end else if (rb_accept_s) begin
                        rb_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rb_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, before the first reset edge lands.
    assign s_ready   = pReset_n & s_ready_s;
    assign shift_en  = pReset_n & shift_en_s;
    assign ccff_head = pReset_n & head_s;
    assign rb_data   = pReset_n ? rb_data_r : WORD_W'(0);
    assign rb_valid  = pReset_n & rb_valid_r;
    assign busy      = pReset_n & busy_r;
    assign done      = pReset_n & done_r;

endmodule
